bcd_seven_seg_scan: RTL and testbench
=====================================

# bcd_seven_seg_scan

Time-multiplexed 3-digit seven-segment display driver that sits directly downstream of the binary-to-BCD converter. It snapshots the `ones`/`tens`/`hundreds` BCD digits on a load strobe and scans them onto a shared segment bus with one anode enable per digit. It inserts a one-cycle all-off gap between digits to prevent ghosting, optionally blanks leading zeros, and pulses at the end of each full scan frame.

## Interface
- `REFRESH_DIV`, 1000: clock cycles each digit is lit per visit; legal range ≥ 2.
- `ACTIVE_LOW`, 1: when 1, `seg` and `an` are both inverted at the output register (common-anode board); when 0, active-high.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `load` input 1: capture strobe; samples the three digit inputs into shadow registers.
- `ones` input 4: BCD digit 0, least significant.
- `tens` input 4: BCD digit 1.
- `hundreds` input 4: BCD digit 2.
- `blank_lz` input 1: leading-zero blanking enable; sampled every cycle.
- `seg` output 7: segment drive, bit0 = a … bit6 = g; registered.
- `an` output 3: digit enables, bit0 = ones, bit2 = hundreds; registered; at most one active.
- `frame_done` output 1: one-cycle pulse on entry to the gap that follows the hundreds digit.

## Operation
- Shadow registers `sh_o`, `sh_t`, `sh_h` are loaded when `load`=1. Otherwise they hold.
- FSM has two states, SHOW and GAP. It also keeps a digit index `idx` (0..2) and a refresh counter `cnt` of width `$clog2(REFRESH_DIV)`.
- In SHOW, `cnt` increments. When `cnt` = REFRESH_DIV-1: go to GAP, clear `cnt`, and set `frame_done`=1 if `idx`=2.
- From GAP, the FSM always goes to SHOW after one cycle, with `idx` advancing 0→1→2→0 (wraps 2→0).
- SHOW output: `an` has only bit `idx` active, and `seg` = decode(shadow digit `idx`).
- GAP output: `an` all inactive, and `seg` all inactive.
- Leading-zero blanking, evaluated on shadow values:
  - If `blank_lz`=1 and `sh_h`=0, the hundreds digit is blanked: `an` and `seg` are inactive throughout its SHOW slot, but the slot length is unchanged.
  - If `blank_lz`=1 and both `sh_h`=0 and `sh_t`=0, tens is blanked as well.
  - Ones is never blanked.
- Decoder, logical active-high values before `ACTIVE_LOW` inversion:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10–15 display a dash (40).

## Timing
- Reset (`rst_n`=0 at an edge): state GAP, `idx`=2, `cnt`=0, shadows=0, `frame_done`=0, `seg` and `an` inactive (all 1s when `ACTIVE_LOW`=1).
- First edge after reset release enters SHOW with `idx`=0. Ones is lit from that edge onward.
- Outputs are registered from next-state. `seg`/`an` take the values for a state on the same edge the FSM enters it.
- Per-digit period is REFRESH_DIV+1 cycles. Frame period is 3·(REFRESH_DIV+1).
- `load` sampled at edge N: the new shadow value drives `seg` from edge N+1, even mid-SHOW, with no wait for a digit boundary.
- If `load` and a SHOW→GAP transition occur on the same edge, the new value is shown at the next SHOW of that digit.
- `rst_n`=0 mid-scan aborts immediately to the reset state above. Shadows clear, and no `frame_done` is emitted for the partial frame.
- A `blank_lz` change takes effect at the next edge.

## Structure
- Shared package `seg_pkg` holds:
  - state enum `{SHOW, GAP}`;
  - the eleven 7-bit segment pattern constants;
  - `NUM_DIGITS`=3.
- Sub-module `bcd_to_seg` is purely combinational: a 4-bit code goes in, the 7-bit active-high pattern comes out. Its output is registered in the parent.
- Top level holds the FSM, the counter, the shadow registers, the blanking logic and the polarity inversion.

## Test plan
All scenarios use REFRESH_DIV=4 and ACTIVE_LOW=0.
- Reset release, no `load` → cycle 1: `an`=001, `seg`=3F for 4 cycles. Then 1 gap cycle (`an`=000, `seg`=00). Then `an`=010, gap, `an`=100, then `frame_done` pulse; frame period 15 cycles.
- `load` with h=2, t=5, o=7, `blank_lz`=0 → successive slots show `seg` 07 (`an`=001), 6D (`an`=010), 5B (`an`=100).
- `blank_lz`=1, `load` h=0, t=0, o=4 → ones slot shows 66. Tens and hundreds slots keep `an`=000 and `seg`=00 for full length.
- `blank_lz`=1 with h=0, t=3, o=0 → tens shows 4F and ones shows 3F. Only hundreds is blanked.
- `load` o=12 → ones slot shows 40 (dash).
- `load` o=1 during the 2nd cycle of the ones slot → `seg` changes to 06 on the next edge. Then assert `rst_n`=0 mid-tens slot → `an`/`seg`=0 and no `frame_done`. After release, the scan restarts at ones showing 3F.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the 3-digit seven-segment scan driver.
// Segment patterns are logical active-high, bit0 = a ... bit6 = g.
package seg_pkg;

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } state_e;

    localparam int NUM_DIGITS = 3;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_code)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seven_seg_scan.sv
// Time-multiplexed 3-digit seven-segment driver with inter-digit gap,
// leading-zero blanking and end-of-frame pulse. Outputs registered from next-state.
module bcd_seven_seg_scan
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 1000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [3:0]            i_ones,
    input  logic [3:0]            i_tens,
    input  logic [3:0]            i_hundreds,
    input  logic                  i_blank_lz,
    output logic [6:0]            o_seg,
    output logic [NUM_DIGITS-1:0] o_an,
    output logic                  o_frame_done,
    output state_e                o_dbg_state
);

    localparam int                  CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [1:0]          IDX_LAST = 2'(NUM_DIGITS - 1);
    localparam logic [6:0]          SEG_POL  = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_POL = ACTIVE_LOW ? '1 : '0;

    state_e                r_state;
    logic [1:0]            r_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic [3:0]            r_sh_o;
    logic [3:0]            r_sh_t;
    logic [3:0]            r_sh_h;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_fd;

    state_e                w_state_nx;
    logic [1:0]            w_idx_nx;
    logic [CNT_W-1:0]      w_cnt_nx;
    logic                  w_fd_nx;
    logic [3:0]            w_digit;
    logic [6:0]            w_seg_dec;
    logic                  w_blank;
    logic                  w_lit;
    logic [6:0]            w_seg_log;
    logic [NUM_DIGITS-1:0] w_an_log;

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_cnt_nx   = r_cnt;
        w_fd_nx    = 1'b0;
        case (r_state)
            SHOW: begin
                if (r_cnt == CNT_MAX) begin
                    w_state_nx = GAP;
                    w_cnt_nx   = '0;
                    w_fd_nx    = (r_idx == IDX_LAST);
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            GAP: begin
                w_state_nx = SHOW;
                w_cnt_nx   = '0;
                w_idx_nx   = (r_idx == IDX_LAST) ? 2'd0 : r_idx + 2'd1;
            end
            default: begin
                w_state_nx = GAP;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Pattern for the upcoming digit, taken from the current shadows so a
    // load at edge N is visible from edge N+1.
    always_comb begin
        w_digit = r_sh_o;
        case (w_idx_nx)
            2'd1:    w_digit = r_sh_t;
            2'd2:    w_digit = r_sh_h;
            default: w_digit = r_sh_o;
        endcase
    end

    bcd_to_seg u_dec (
        .i_code (w_digit),
        .o_seg  (w_seg_dec)
    );

    always_comb begin
        w_blank   = i_blank_lz && (r_sh_h == 4'd0) &&
                    ((w_idx_nx == 2'd2) || ((w_idx_nx == 2'd1) && (r_sh_t == 4'd0)));
        w_lit     = (w_state_nx == SHOW) && !w_blank;
        w_an_log  = w_lit ? NUM_DIGITS'(1 << w_idx_nx) : '0;
        w_seg_log = w_lit ? w_seg_dec : 7'h00;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= GAP;
            r_idx   <= IDX_LAST;
            r_cnt   <= '0;
            r_sh_o  <= 4'd0;
            r_sh_t  <= 4'd0;
            r_sh_h  <= 4'd0;
            r_fd    <= 1'b0;
            r_seg   <= SEG_POL;
            r_an    <= AN_POL;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_cnt   <= w_cnt_nx;
            r_fd    <= w_fd_nx;
            r_seg   <= w_seg_log ^ SEG_POL;
            r_an    <= w_an_log ^ AN_POL;
            if (i_load) begin
                r_sh_o <= i_ones;
                r_sh_t <= i_tens;
                r_sh_h <= i_hundreds;
            end
        end
    end

    assign o_seg        = r_seg;
    assign o_an         = r_an;
    assign o_frame_done = r_fd;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_bcd_seven_seg_scan.sv
// Bench for bcd_seven_seg_scan: directed scenarios then random traffic, checked
// every cycle against a frame-position model of the display.
module tb_bcd_seven_seg_scan;
    import seg_pkg::*;

    localparam int DIV   = 4;
    localparam int SLOT  = DIV + 1;
    localparam int FRAME = 3 * SLOT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [3:0] ones = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [3:0] hundreds = 4'd0;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_done;
    state_e     dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int         t_since = 0;
    logic [3:0] m_o = 4'd0;
    logic [3:0] m_t = 4'd0;
    logic [3:0] m_h = 4'd0;
    logic [6:0] e_seg;
    logic [2:0] e_an;
    logic       e_fd;
    logic       e_gap;
    logic [6:0] pat [16];

    bcd_seven_seg_scan #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b0)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_load       (load),
        .i_ones       (ones),
        .i_tens       (tens),
        .i_hundreds   (hundreds),
        .i_blank_lz   (blank_lz),
        .o_seg        (seg),
        .o_an         (an),
        .o_frame_done (frame_done),
        .o_dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Expected display after an edge, from position in the frame and old shadows.
    task automatic model_outputs();
        int p, d, s;
        logic [3:0] v;
        logic blanked;
        p = (t_since - 1) % FRAME;
        d = p / SLOT;
        s = p % SLOT;
        e_fd  = 1'b0;
        e_gap = (s == SLOT - 1);
        e_an  = 3'b000;
        e_seg = 7'h00;
        if (e_gap) begin
            e_fd = (d == 2);
        end else begin
            v = (d == 0) ? m_o : (d == 1) ? m_t : m_h;
            blanked = blank_lz && (m_h == 4'd0) && ((d == 2) || (d == 1 && m_t == 4'd0));
            if (!blanked) begin
                e_an  = 3'(1 << d);
                e_seg = pat[v];
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) begin
            t_since = 0;
            m_o = 4'd0; m_t = 4'd0; m_h = 4'd0;
            e_an = 3'b000; e_seg = 7'h00; e_fd = 1'b0; e_gap = 1'b1;
        end else begin
            t_since++;
            model_outputs();
            if (load) begin
                m_o = ones; m_t = tens; m_h = hundreds;
            end
        end
        #1;
        check("an",         {5'd0, an},          {5'd0, e_an});
        check("seg",        {1'b0, seg},         {1'b0, e_seg});
        check("frame_done", {7'd0, frame_done},  {7'd0, e_fd});
        check("state_gap",  {7'd0, dbg_state == GAP}, {7'd0, e_gap});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        hundreds = h; tens = t; ones = o; load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    initial begin
        pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B; pat[3] = 7'h4F;
        pat[4] = 7'h66; pat[5] = 7'h6D; pat[6] = 7'h7D; pat[7] = 7'h07;
        pat[8] = 7'h7F; pat[9] = 7'h6F;
        for (int i = 10; i < 16; i++) pat[i] = 7'h40;

        // Reset, then a free-running frame with zero shadows
        run(2);
        rst_n = 1'b1;
        run(FRAME + 1);

        // 257 without blanking
        do_load(4'd2, 4'd5, 4'd7);
        run(FRAME + 2);

        // 004 with blanking: tens and hundreds dark
        blank_lz = 1'b1;
        do_load(4'd0, 4'd0, 4'd4);
        run(FRAME + 2);

        // 030 with blanking: only hundreds dark
        do_load(4'd0, 4'd3, 4'd0);
        run(FRAME + 2);

        // Non-BCD ones code shows a dash
        blank_lz = 1'b0;
        do_load(4'd0, 4'd0, 4'd12);
        run(FRAME + 2);

        // Mid-slot load then reset inside the tens slot
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        cycle();
        do_load(4'd0, 4'd0, 4'd1);
        run(5);
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(FRAME + 2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            load     = ($urandom_range(0, 7) == 0);
            ones     = 4'($urandom_range(0, 15));
            tens     = 4'($urandom_range(0, 15));
            hundreds = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            rst_n    = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
